// File: rtl/morse_msg_sequencer.sv
// rtl/morse_msg_sequencer.sv - letter FIFO feeding a Morse letter encoder with inter-letter/word gap timing
module morse_msg_sequencer #(
    parameter int DEPTH    = 8,
    parameter int UNIT_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [4:0] wr_code,
    input  logic       clear,
    output logic       enc_start,
    output logic [4:0] enc_code,
    input  logic       enc_done,
    output logic       full,
    output logic       empty,
    output logic [4:0] count,
    output logic       busy,
    output logic       wr_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
    localparam logic [4:0]    DEPTH_C    = 5'(DEPTH);
    localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_GAP
    } state_t;

    logic [4:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic          wr_err_q, wr_err_d;

    state_t        state_q, state_d;
    logic [4:0]    cur_code_q, cur_code_d;
    logic [2:0]    gap_units_q, gap_units_d;
    logic [PW-1:0] presc_q, presc_d;

    logic code_legal;
    logic push;
    logic pop;

    assign code_legal = (wr_code <= 5'd26);
    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == 5'd0);
    // full is the registered occupancy, so a same-cycle pop never frees room for a write
    assign push       = wr_en & code_legal & ~full & ~clear;
    assign pop        = (state_q == S_IDLE) & ~empty;

    assign count  = count_q;
    assign busy   = (state_q != S_IDLE);
    assign wr_err = wr_err_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wr_err_d = wr_en & ~clear & (full | ~code_legal);
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + 5'd1;
            end else if (pop && !push) begin
                count_d = count_q - 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wr_err_q <= wr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_code_d  = cur_code_q;
        gap_units_d = gap_units_q;
        presc_d     = presc_q;
        enc_start   = 1'b0;
        enc_code    = 5'd0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    cur_code_d = mem_q[rd_ptr_q];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cur_code_q != 5'd0) begin
                    enc_start = 1'b1;
                    enc_code  = cur_code_q;
                    state_d   = S_WAIT;
                end else begin
                    // word space: 4 extra units on top of the 3-unit letter gap
                    gap_units_d = 3'd4;
                    presc_d     = '0;
                    state_d     = S_GAP;
                end
            end
            S_WAIT: begin
                if (enc_done) begin
                    gap_units_d = 3'd2;
                    presc_d     = '0;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d     = '0;
                    gap_units_d = gap_units_q - 3'd1;
                    if (gap_units_q <= 3'd1) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_code_q  <= 5'd0;
            gap_units_q <= 3'd0;
            presc_q     <= '0;
        end else begin
            state_q     <= state_d;
            cur_code_q  <= cur_code_d;
            gap_units_q <= gap_units_d;
            presc_q     <= presc_d;
        end
    end

endmodule

// File: doc/morse_msg_sequencer.md
MORSE_MSG_SEQUENCER -- requirements
Module: morse_msg_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: letter FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter UNIT_DIV, default 1: clk cycles per Morse unit tick (>=1).
REQ-003 SHALL have port clk  input  1  system clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  write request for wr_code.
REQ-006 SHALL have port wr_code  input  5  0 = word space, 1..26 = letters A..Z, 27..31 illegal.
REQ-007 SHALL have port clear  input  1  synchronous FIFO flush.
REQ-008 SHALL have port enc_start  output  1  one-cycle encode request to the letter encoder.
REQ-009 SHALL have port enc_code  output  5  letter code (1..26), valid while enc_start is high.
REQ-010 SHALL have port enc_done  input  1  one-cycle pulse from the encoder when its letter pattern is complete.
REQ-011 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-012 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-013 SHALL have port count  output  5  FIFO occupancy, 0..DEPTH.
REQ-014 SHALL have port busy  output  1  FSM not in IDLE.
REQ-015 SHALL have port wr_err  output  1  one-cycle pulse on a rejected write.

Function
REQ-016 FIFO: wr_en with a legal code and full=0 SHALL store wr_code at the tail; count +1 on the following edge.
REQ-017 wr_en while full=1, or with wr_code 27..31, SHALL store nothing and pulse wr_err the next cycle; full is sampled before any same-cycle pop.
REQ-018 A same-cycle write and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-019 clear SHALL zero count and both pointers next edge, override a same-cycle write (no wr_err), and leave the FSM state untouched.
REQ-020 FSM states: IDLE, ISSUE, WAIT, GAP; encoding is free.
REQ-021 IDLE: if empty=0, pop head into cur_code and go to ISSUE next edge; else stay IDLE.
REQ-022 ISSUE, cur_code 1..26: drive enc_start=1 and enc_code=cur_code for exactly this one cycle, then go to WAIT.
REQ-023 ISSUE, cur_code 0: no enc_start; load gap_units=4 and go to GAP.
REQ-024 WAIT: hold until enc_done=1, then load gap_units=2 and go to GAP; enc_done outside WAIT SHALL be ignored.
REQ-025 Unit prescaler SHALL restart at 0 on GAP entry and tick every UNIT_DIV cycles, so GAP lasts exactly gap_units*UNIT_DIV cycles before returning to IDLE.
REQ-026 Gap accounting: the encoder's trailing 1-unit off plus the 2-unit gap gives 3 units between letters. A space adds 4 units, giving a 7-unit word gap.
REQ-027 Minimum letter-to-letter overhead with a non-empty FIFO SHALL be IDLE(1) + ISSUE(1) cycles after GAP ends.
REQ-028 enc_start SHALL never be asserted outside ISSUE; enc_code SHALL read 0 whenever enc_start=0.
REQ-029 busy SHALL be 1 in ISSUE, WAIT and GAP.
REQ-030 full, empty and count SHALL be registered-consistent (full == (count==DEPTH), empty == (count==0)).

Reset
REQ-031 rst=1 SHALL asynchronously force IDLE, count=0, pointers=0, prescaler=0, gap_units=0.
REQ-032 While rst=1, outputs SHALL be enc_start=0, enc_code=0, wr_err=0, busy=0, empty=1, full=0.
REQ-033 Reset mid-WAIT SHALL abandon the letter; any enc_done arriving after reset release SHALL be ignored.
REQ-034 The first write SHALL be accepted on the first rising edge after rst deasserts.

Verification (UNIT_DIV=1, DEPTH=8, encoder model returns enc_done 5 cycles after enc_start)
REQ-035 Write 1 (A) into an idle block -> pop next edge, enc_start with enc_code=1 one cycle later, enc_done after 5 cycles, GAP 2 cycles, back to IDLE with busy=0.
REQ-036 Write 8,5,0,12 -> enc_code sequence 8,5,12; GAP after 5 = 2 cycles, then space GAP = 4 cycles with no enc_start.
REQ-037 Write 9 codes while the FSM holds in WAIT -> full=1 after 8 writes, 9th write pulses wr_err, count stays 8.
REQ-038 Write code 27 -> wr_err pulse, count unchanged, no enc_start.
REQ-039 count=3 plus clear and wr_en in the same cycle -> count=0, empty=1, no wr_err; the in-flight letter still completes.
REQ-040 Assert rst during WAIT, then inject enc_done -> FSM stays IDLE with enc_start=0 and busy=0.
